// File: rtl/pad_io_ctrl.sv
// Pad I/O controller: direction FSM with turnaround dead cycles,
// synchronised glitch-filtered input path and a pad attribute register.
module pad_io_ctrl #(
    parameter int                  PADATTR   = 16,
    parameter int                  FILT_W    = 4,
    parameter int                  TA_CYCLES = 2,
    parameter logic [PADATTR-1:0]  ATTR_RST  = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_out_i,
    input  logic               core_oe_req_i,
    output logic               core_oe_ack_o,
    output logic               core_in_o,
    output logic               core_rise_o,
    output logic               core_fall_o,
    input  logic [FILT_W-1:0]  filt_thr_i,
    input  logic [PADATTR-1:0] attr_i,
    input  logic               attr_we_i,
    output logic               pad_in_o,
    output logic               pad_oe_o,
    input  logic               pad_out_i,
    output logic [PADATTR-1:0] pad_attributes_o
);

    typedef enum logic [1:0] {
        S_IN,
        S_TA_OUT,
        S_OUT,
        S_TA_IN
    } dir_t;

    localparam logic [7:0] TA_LOAD = 8'(TA_CYCLES);

    dir_t              state;
    logic [7:0]        ta_cnt;
    logic              q1;
    logic              q2;
    logic [FILT_W-1:0] flt_cnt;

    // Direction FSM; pad_oe_o is set/cleared on the transitions into/out of OUT
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IN;
            ta_cnt   <= '0;
            pad_oe_o <= 1'b0;
        end else begin
            unique case (state)
                S_IN: begin
                    if (core_oe_req_i) begin
                        state  <= S_TA_OUT;
                        ta_cnt <= TA_LOAD;
                    end
                end
                S_TA_OUT: begin
                    if (!core_oe_req_i) begin
                        state <= S_IN;
                    end else if (ta_cnt == 8'd1) begin
                        state    <= S_OUT;
                        pad_oe_o <= 1'b1;
                    end else begin
                        ta_cnt <= ta_cnt - 8'd1;
                    end
                end
                S_OUT: begin
                    if (!core_oe_req_i) begin
                        state    <= S_TA_IN;
                        ta_cnt   <= TA_LOAD;
                        pad_oe_o <= 1'b0;
                    end
                end
                S_TA_IN: begin
                    if (ta_cnt == 8'd1) begin
                        state <= S_IN;
                    end else begin
                        ta_cnt <= ta_cnt - 8'd1;
                    end
                end
                default: begin
                    state    <= S_IN;
                    pad_oe_o <= 1'b0;
                end
            endcase
        end
    end

    assign core_oe_ack_o = pad_oe_o;

    // >= (not ==) so a threshold lowered mid-count updates on the next mismatch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q1          <= 1'b0;
            q2          <= 1'b0;
            flt_cnt     <= '0;
            core_in_o   <= 1'b0;
            core_rise_o <= 1'b0;
            core_fall_o <= 1'b0;
        end else begin
            q1          <= pad_out_i;
            q2          <= q1;
            core_rise_o <= 1'b0;
            core_fall_o <= 1'b0;
            if (q2 != core_in_o) begin
                if (flt_cnt >= filt_thr_i) begin
                    core_in_o   <= q2;
                    flt_cnt     <= '0;
                    core_rise_o <= q2;
                    core_fall_o <= ~q2;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_in_o         <= 1'b0;
            pad_attributes_o <= ATTR_RST;
        end else begin
            pad_in_o <= core_out_i;
            if (attr_we_i) begin
                pad_attributes_o <= attr_i;
            end
        end
    end

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Bench for pad_io_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural reference model.
module tb_pad_io_ctrl;

    localparam int PA = 16;
    localparam int FW = 4;
    localparam int TA = 2;
    localparam logic [PA-1:0] ARST = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          core_out = 1'b0;
    logic          req = 1'b0;
    logic [FW-1:0] thr = '0;
    logic [PA-1:0] attr = '0;
    logic          attr_we = 1'b0;
    logic          pad_out = 1'b0;
    logic          ack, cin, rise, fall, pad_in, oe;
    logic [PA-1:0] attrs;

    int n_cmp = 0;
    int n_err = 0;

    pad_io_ctrl #(
        .PADATTR(PA), .FILT_W(FW), .TA_CYCLES(TA), .ATTR_RST(ARST)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_out_i(core_out), .core_oe_req_i(req),
        .core_oe_ack_o(ack), .core_in_o(cin),
        .core_rise_o(rise), .core_fall_o(fall),
        .filt_thr_i(thr), .attr_i(attr), .attr_we_i(attr_we),
        .pad_in_o(pad_in), .pad_oe_o(oe), .pad_out_i(pad_out),
        .pad_attributes_o(attrs)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=receive 1=going out 2=driving 3=going in
    int            m_mode = 0;
    int            m_left = 0;
    int            m_run = 0;
    logic          m_in = 1'b0;
    logic          m_rise = 1'b0;
    logic          m_fall = 1'b0;
    logic          m_pad_in = 1'b0;
    logic [PA-1:0] m_attr = ARST;
    logic          hist[$];
    logic          v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_left = 0; m_run = 0;
            m_in = 0; m_rise = 0; m_fall = 0;
            m_pad_in = 0; m_attr = ARST;
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
        end else begin
            hist.push_back(pad_out);
            v = hist[0];
            void'(hist.pop_front());
            m_rise = 0; m_fall = 0;
            if (v !== m_in) begin
                m_run++;
                if (m_run > int'(thr)) begin
                    m_in = v; m_run = 0; m_rise = v; m_fall = !v;
                end
            end else begin
                m_run = 0;
            end
            m_pad_in = core_out;
            if (attr_we) m_attr = attr;
            case (m_mode)
                0: if (req) begin m_mode = 1; m_left = TA; end
                1: if (!req) m_mode = 0;
                   else begin m_left--; if (m_left == 0) m_mode = 2; end
                2: if (!req) begin m_mode = 3; m_left = TA; end
                default: begin m_left--; if (m_left == 0) m_mode = 0; end
            endcase
        end
    end

    function automatic logic [21:0] exp_vec();
        logic d;
        d = (m_mode == 2);
        return {d, d, m_in, m_rise, m_fall, m_pad_in, m_attr};
    endfunction

    wire [21:0] obs = {oe, ack, cin, rise, fall, pad_in, attrs};

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {6'b0, ARST}) begin
            n_err++;
            $display("FAIL reset_async obs=%h expected %h", obs, {6'b0, ARST});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_hold obs=%h expected %h", obs, exp_vec());
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_dir_timing();
        logic e;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            e = (c >= 3 && c <= 10) || (c >= 16);
            n_cmp++;
            if (oe !== e || ack !== e) begin
                n_err++;
                $display("FAIL dir_timing c=%0d oe=%b ack=%b expected %b", c, oe, ack, e);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL dir_model c=%0d obs=%h expected %h", c, obs, exp_vec());
            end
            req = (c < 10) || (c >= 13);
        end
        req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_abort();
        logic e;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (oe !== 1'b0) begin
                n_err++;
                $display("FAIL abort c=%0d oe=%b expected 0", c, oe);
            end
            req = (c == 0);
        end
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e = (c >= 3);
            n_cmp++;
            if (oe !== e) begin
                n_err++;
                $display("FAIL abort_retry c=%0d oe=%b expected %b", c, oe, e);
            end
            req = 1'b1;
        end
        req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_attr_ta_in();
        logic          e;
        logic [PA-1:0] ea;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            e  = (c >= 3 && c <= 5) || (c >= 11);
            ea = (c >= 7) ? 16'hA5A5 : ARST;
            n_cmp++;
            if (oe !== e || attrs !== ea) begin
                n_err++;
                $display("FAIL attr_ta_in c=%0d oe=%b attr=%h expected %b %h",
                         c, oe, attrs, e, ea);
            end
            req     = (c < 5) || (c >= 8);
            attr    = 16'hA5A5;
            attr_we = (c == 6);
        end
        req = 1'b0;
        attr_we = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_filter();
        logic ei;
        thr = 4'd3;
        pad_out = 1'b0;
        repeat (4) @(negedge clk);
        for (int j = 0; j <= 11; j++) begin
            if (j > 0) @(negedge clk);
            n_cmp++;
            if (cin !== 1'b0 || rise !== 1'b0) begin
                n_err++;
                $display("FAIL filt_short j=%0d in=%b rise=%b expected 0 0", j, cin, rise);
            end
            pad_out = (j < 3);
        end
        for (int j = 0; j <= 15; j++) begin
            @(negedge clk);
            ei = (j >= 6 && j < 12);
            n_cmp++;
            if (cin !== ei || rise !== (j == 6) || fall !== (j == 12)) begin
                n_err++;
                $display("FAIL filt_long j=%0d in/rise/fall=%b%b%b expected %b%b%b",
                         j, cin, rise, fall, ei, j == 6, j == 12);
            end
            pad_out = (j < 6);
        end
    endtask

    task automatic test_fast();
        thr = 4'd0;
        pad_out = 1'b0;
        repeat (4) @(negedge clk);
        for (int j = 0; j <= 7; j++) begin
            if (j > 0) @(negedge clk);
            n_cmp++;
            if (cin !== (j == 3) || rise !== (j == 3) || fall !== (j == 4)) begin
                n_err++;
                $display("FAIL filt_fast j=%0d in/rise/fall=%b%b%b expected %b%b%b",
                         j, cin, rise, fall, j == 3, j == 3, j == 4);
            end
            pad_out = (j == 0);
        end
    endtask

    task automatic test_reset_mid_out();
        req = 1'b1;
        repeat (5) @(negedge clk);
        attr = 16'h00FF;
        attr_we = 1'b1;
        @(negedge clk);
        attr_we = 1'b0;
        n_cmp++;
        if (oe !== 1'b1 || attrs !== 16'h00FF) begin
            n_err++;
            $display("FAIL pre_reset oe=%b attr=%h expected 1 00ff", oe, attrs);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (oe !== 1'b0 || ack !== 1'b0 || attrs !== ARST) begin
            n_err++;
            $display("FAIL reset_mid_out oe=%b ack=%b attr=%h expected 0 0 %h",
                     oe, ack, attrs, ARST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            n_cmp++;
            if (oe !== (c >= 3)) begin
                n_err++;
                $display("FAIL post_reset_ta c=%0d oe=%b expected %b", c, oe, c >= 3);
            end
        end
        req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random i=%0d obs=%h expected %h", i, obs, exp_vec());
            end
            core_out = 1'($urandom);
            if ($urandom_range(0, 5) == 0) req = ~req;
            if ($urandom_range(0, 2) == 0) pad_out = ~pad_out;
            if ($urandom_range(0, 40) == 0) thr = FW'($urandom_range(0, 3));
            attr_we = ($urandom_range(0, 9) == 0);
            attr = PA'($urandom);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_dir_timing();
        test_abort();
        test_attr_ta_in();
        test_filter();
        test_fast();
        test_reset_mid_out();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pad_io_ctrl.md
PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

Interface
REQ-001 Parameter PADATTR, default 16: width of the pad attribute bus.
REQ-002 Parameter FILT_W, default 4: width of the input glitch-filter counter and threshold.
REQ-003 Parameter TA_CYCLES, default 2: direction-turnaround dead cycles, legal range 1..255.
REQ-004 Parameter ATTR_RST, default 0 (PADATTR bits): reset value of pad_attributes_o.
REQ-005 clk_i  input  1  single clock for the whole block.
REQ-006 rst_ni  input  1  reset, asynchronous and active-low.
REQ-007 core_out_i  input  1  value the core wants driven onto the pad.
REQ-008 core_oe_req_i  input  1  core request for output direction (1 = drive, 0 = receive).
REQ-009 core_oe_ack_o  output  1  high while the pad is actually driven.
REQ-010 core_in_o  output  1  synchronised, glitch-filtered pad value.
REQ-011 core_rise_o  output  1  one-cycle pulse on a filtered rising edge.
REQ-012 core_fall_o  output  1  one-cycle pulse on a filtered falling edge.
REQ-013 filt_thr_i  input  FILT_W  filter threshold: the number of extra stable cycles required.
REQ-014 attr_i  input  PADATTR  new pad attribute value.
REQ-015 attr_we_i  input  1  attribute write strobe.
REQ-016 pad_in_o  output  1  drive value to the pad cell data input.
REQ-017 pad_oe_o  output  1  output enable to the pad cell.
REQ-018 pad_out_i  input  1  pad cell received value, asynchronous to clk_i.
REQ-019 pad_attributes_o  output  PADATTR  attributes to the pad cell.

Function
REQ-020 The direction FSM SHALL have the states IN, TA_OUT, OUT and TA_IN, and pad_oe_o SHALL be registered and high only in OUT.
REQ-021 The FSM SHALL make these transitions:
- IN with core_oe_req_i=1: to TA_OUT, turnaround counter loaded with TA_CYCLES.
- TA_OUT: counter decrements each cycle; at 1, to OUT; if core_oe_req_i=0 at any point, back to IN the next cycle (abort).
- OUT with core_oe_req_i=0: to TA_IN, counter loaded with TA_CYCLES.
- TA_IN: always completes its TA_CYCLES; requests are ignored until the FSM is back in IN, where they are re-evaluated.
REQ-022 From a core_oe_req_i rise sampled in IN, pad_oe_o SHALL rise exactly TA_CYCLES+1 cycles later.
REQ-023 pad_oe_o SHALL fall on the first clock edge that samples core_oe_req_i=0 in OUT.
REQ-024 core_oe_ack_o SHALL equal pad_oe_o.
REQ-025 pad_in_o SHALL be core_out_i registered, with one-cycle latency in every state.
REQ-026 pad_out_i SHALL pass through a 2-flop synchroniser (q1, q2) before filtering.
REQ-027 The filter SHALL update on each edge as follows:
- q2 differs from core_in_o and count = filt_thr_i: core_in_o takes q2 and count clears.
- q2 differs and count < filt_thr_i: count increments.
- q2 equals core_in_o: count clears.
REQ-028 If pad_out_i is stable from edge k, core_in_o SHALL change at edge k+2+filt_thr_i; a pulse shorter than filt_thr_i+1 synchronised cycles SHALL be rejected.
REQ-029 The count SHALL never exceed filt_thr_i, so no wrap-around occurs.
REQ-030 A change of filt_thr_i mid-count SHALL take effect on the next comparison; if count > new threshold, the next differing cycle updates core_in_o.
REQ-031 core_rise_o and core_fall_o SHALL be registered and asserted in exactly the cycle core_in_o becomes 1 or 0 respectively; they SHALL never both be high.
REQ-032 The input path SHALL operate in all FSM states, giving driven-value readback in OUT.
REQ-033 attr_we_i=1 SHALL load attr_i into pad_attributes_o at the next edge, independent of FSM state.

Reset
REQ-034 While rst_ni=0, the block SHALL immediately, without a clock, force: state IN, pad_oe_o=0, pad_in_o=0, core_oe_ack_o=0, core_in_o=0, core_rise_o=0, core_fall_o=0, synchroniser and counters cleared, pad_attributes_o=ATTR_RST.
REQ-035 A reset asserted in OUT or TA_OUT SHALL drop pad_oe_o within the same cycle, with no turnaround.
REQ-036 After reset release, the first core_oe_req_i=1 SHALL undergo a full TA_OUT.

Verification
REQ-037 The bench SHALL cover: TA_CYCLES=2, core_oe_req_i rises at cycle 0 -> pad_oe_o=1 from cycle 3; req falls at cycle 10 -> pad_oe_o=0 at cycle 11, FSM back in IN at cycle 13.
REQ-038 The bench SHALL cover: req=1 for 1 cycle, then 0 while in TA_OUT -> pad_oe_o stays 0 and FSM returns to IN.
REQ-039 The bench SHALL cover: filt_thr_i=3, pad_out_i high for 3 cycles -> core_in_o stays 0; high for 6 cycles -> core_in_o=1 at edge k+5, with core_rise_o a single 1-cycle pulse.
REQ-040 The bench SHALL cover: filt_thr_i=0, pad_out_i toggles 1,0 -> core_rise_o then core_fall_o on consecutive cycles, 2 cycles after the input.
REQ-041 The bench SHALL cover: rst_ni pulled low mid-OUT with attr=0x00FF written -> pad_oe_o=0 asynchronously and pad_attributes_o=ATTR_RST.
REQ-042 The bench SHALL cover: attr_we_i with attr_i=0xA5A5 during TA_IN -> pad_attributes_o=0xA5A5 next cycle and the FSM timing is unaffected.
